// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button front end.
// The optional auto-repeat feature is selected by the BTN_AUTO_REPEAT_EN macro.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  // Counter width large enough to hold the largest terminal count minus one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/btn_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous input.
// Flops reset to RESET_VAL so the output starts at a known idle level.
module btn_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{RESET_VAL}};
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/button_pulse_generator.sv
// Debounces a raw push button into a clean level and a one-cycle pulse per press.
// Define BTN_AUTO_REPEAT_EN to add timed auto-repeat pulses while the button is held.
module button_pulse_generator
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BTN_ACTIVE_LOW  = 0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic pulse
);

  localparam int   CNT_W        = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic RELEASED_RAW = (BTN_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  logic             btn_sync;
  logic             btn_s;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
`ifdef BTN_AUTO_REPEAT_EN
  logic             rpt_armed;
`endif

  btn_synchronizer #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(RELEASED_RAW)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_in),
    .q    (btn_sync)
  );

  // Normalize polarity so 1 always means pressed.
  assign btn_s = btn_sync ^ RELEASED_RAW;

  // Debounce FSM with stability counter; level and pulse are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      btn_level <= 1'b0;
      pulse     <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rpt_armed <= 1'b0;
`endif
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          btn_level <= 1'b0;
          cnt       <= '0;
          if (btn_s) state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state     <= PRESSED;
            cnt       <= '0;
            pulse     <= 1'b1;
            btn_level <= 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_armed <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          btn_level <= 1'b1;
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else begin
`ifdef BTN_AUTO_REPEAT_EN
            // Hold timer: first repeat after the delay, then every period.
            if (!rpt_armed && cnt == RPT_DLY_LAST) begin
              pulse     <= 1'b1;
              cnt       <= '0;
              rpt_armed <= 1'b1;
            end else if (rpt_armed && cnt == RPT_PER_LAST) begin
              pulse <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
`else
            cnt <= '0;
`endif
          end
        end
        RELEASE_WAIT: begin
          btn_level <= 1'b1;
          if (btn_s) begin
            state <= PRESSED;
            cnt   <= '0;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_armed <= 1'b0;
`endif
          end else if (cnt == DB_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_pulse_generator.sv
// Bench for button_pulse_generator: an active-high and an active-low instance
// share one logical press stream and are compared against a run-length model.
module tb_button_pulse_generator;

  localparam int SYNC = 2;
  localparam int DB   = 8;
  localparam int RD   = 40;
  localparam int RP   = 16;
  localparam int LAT  = SYNC + 1 + DB;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_hi, btn_lo;
  logic level_hi, pulse_hi, level_lo, pulse_lo;

  int checks   = 0;
  int failures = 0;

  // Reference model state: raw samples still in flight, accepted level,
  // length of the current disagreeing run, and the output pulse.
  logic [SYNC-1:0] m_q;
  logic            m_level;
  logic            m_pulse;
  int              m_run;
`ifdef BTN_AUTO_REPEAT_EN
  int              m_hold;
`endif

  always #5 clk = ~clk;

  button_pulse_generator #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .BTN_ACTIVE_LOW(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_hi), .btn_level(level_hi), .pulse(pulse_hi)
  );

  button_pulse_generator #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .BTN_ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_lo (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_lo), .btn_level(level_lo), .pulse(pulse_lo)
  );

  task automatic model_reset();
    m_q     = '0;
    m_level = 1'b0;
    m_pulse = 1'b0;
    m_run   = 0;
`ifdef BTN_AUTO_REPEAT_EN
    m_hold  = -1;
`endif
  endtask

  // A level change is accepted once the synchronized value has disagreed
  // with the current level for DB+1 consecutive sampling edges.
  task automatic model_edge(input logic p);
    logic s;
`ifdef BTN_AUTO_REPEAT_EN
    logic prev_level;
    prev_level = m_level;
`endif
    s = m_q[SYNC-1];
    m_q = {m_q[SYNC-2:0], p};
    m_pulse = 1'b0;
    if (s != m_level) begin
      m_run++;
      if (m_run == DB + 1) begin
        m_level = s;
        m_run   = 0;
        if (s) m_pulse = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
        m_hold = 0;
`endif
      end
    end else begin
      m_run = 0;
    end
`ifdef BTN_AUTO_REPEAT_EN
    if (m_level && prev_level) begin
      if (!s) m_hold = -1;
      else begin
        m_hold++;
        if (m_hold == RD || (m_hold > RD && ((m_hold - RD) % RP) == 0)) m_pulse = 1'b1;
      end
    end
`endif
  endtask

  // Drive one clock of logical press value p (both polarities) and advance the model.
  task automatic step(input logic p);
    btn_hi = p;
    btn_lo = ~p;
    @(posedge clk);
    if (rst_n) model_edge(p);
    else model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      if ({level_hi, pulse_hi, level_lo, pulse_lo} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_held cyc=%0d got=%b exp=0000", i, {level_hi, pulse_hi, level_lo, pulse_lo});
      end
      checks++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      if ({level_hi, pulse_hi, level_lo, pulse_lo} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=0000", i, {level_hi, pulse_hi, level_lo, pulse_lo});
      end
      checks++;
    end
  endtask

  task automatic test_clean_press();
    int npulse = 0, first_p = 0, first_l = 0, fall = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1'b1);
      if ({level_hi, pulse_hi, level_lo, pulse_lo} !== {m_level, m_pulse, m_level, m_pulse}) begin
        failures++;
        $display("FAIL clean_press cyc=%0d got=%b exp=%b", i,
                 {level_hi, pulse_hi, level_lo, pulse_lo}, {m_level, m_pulse, m_level, m_pulse});
      end
      checks++;
      if (pulse_hi) begin
        npulse++;
        if (first_p == 0) first_p = i;
      end
      if (level_hi && first_l == 0) first_l = i;
    end
    if (npulse !== 1 || first_p !== LAT || first_l !== LAT) begin
      failures++;
      $display("FAIL clean_press_timing pulses=%0d at=%0d level_at=%0d exp 1 at %0d", npulse, first_p, first_l, LAT);
    end
    checks++;
    npulse = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0);
      if ({level_hi, pulse_hi, level_lo, pulse_lo} !== {m_level, m_pulse, m_level, m_pulse}) begin
        failures++;
        $display("FAIL clean_release cyc=%0d got=%b exp=%b", i,
                 {level_hi, pulse_hi, level_lo, pulse_lo}, {m_level, m_pulse, m_level, m_pulse});
      end
      checks++;
      if (pulse_hi) npulse++;
      if (!level_hi && fall == 0) fall = i;
    end
    if (npulse !== 0 || fall !== LAT) begin
      failures++;
      $display("FAIL release_timing pulses=%0d fall_at=%0d exp 0 at %0d", npulse, fall, LAT);
    end
    checks++;
  endtask

  task automatic test_bounce();
    int npulse = 0, first_p = 0;
    for (int i = 0; i < 24; i++) begin
      step(((i / 3) % 2) == 0);
      if ({level_hi, pulse_hi, level_lo, pulse_lo} !== 4'b0000) begin
        failures++;
        $display("FAIL bounce cyc=%0d got=%b exp=0000", i, {level_hi, pulse_hi, level_lo, pulse_lo});
      end
      checks++;
    end
    for (int i = 1; i <= 25; i++) begin
      step(1'b1);
      if ({level_hi, pulse_hi, level_lo, pulse_lo} !== {m_level, m_pulse, m_level, m_pulse}) begin
        failures++;
        $display("FAIL bounce_settle cyc=%0d got=%b exp=%b", i,
                 {level_hi, pulse_hi, level_lo, pulse_lo}, {m_level, m_pulse, m_level, m_pulse});
      end
      checks++;
      if (pulse_hi) begin
        npulse++;
        if (first_p == 0) first_p = i;
      end
    end
    if (npulse !== 1 || first_p !== LAT) begin
      failures++;
      $display("FAIL bounce_pulse pulses=%0d at=%0d exp 1 at %0d", npulse, first_p, LAT);
    end
    checks++;
    for (int i = 0; i < 20; i++) step(1'b0);
  endtask

  task automatic test_tap_glitch();
    int npulse = 0;
    for (int i = 0; i < 20; i++) begin
      step(i < 5);
      if ({level_hi, pulse_hi, level_lo, pulse_lo} !== 4'b0000) begin
        failures++;
        $display("FAIL short_tap cyc=%0d got=%b exp=0000", i, {level_hi, pulse_hi, level_lo, pulse_lo});
      end
      checks++;
    end
    for (int i = 0; i < 40; i++) begin
      step(!(i == 20 || i == 21));
      if ({level_hi, pulse_hi, level_lo, pulse_lo} !== {m_level, m_pulse, m_level, m_pulse}) begin
        failures++;
        $display("FAIL glitch cyc=%0d got=%b exp=%b", i,
                 {level_hi, pulse_hi, level_lo, pulse_lo}, {m_level, m_pulse, m_level, m_pulse});
      end
      checks++;
      if (pulse_hi) npulse++;
    end
    if (npulse !== 1) begin
      failures++;
      $display("FAIL glitch_pulses got=%0d exp=1", npulse);
    end
    checks++;
    for (int i = 0; i < 20; i++) step(1'b0);
  endtask

  task automatic test_reset_mid();
    int npulse = 0;
    for (int i = 0; i < 5; i++) step(1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    if ({level_hi, pulse_hi, level_lo, pulse_lo} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_wait got=%b exp=0000", {level_hi, pulse_hi, level_lo, pulse_lo});
    end
    checks++;
    @(negedge clk);
    step(1'b1);
    rst_n = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step(1'b1);
      if ({level_hi, pulse_hi, level_lo, pulse_lo} !== {m_level, m_pulse, m_level, m_pulse}) begin
        failures++;
        $display("FAIL reset_held_btn cyc=%0d got=%b exp=%b", i,
                 {level_hi, pulse_hi, level_lo, pulse_lo}, {m_level, m_pulse, m_level, m_pulse});
      end
      checks++;
      if (pulse_hi) npulse++;
    end
    if (npulse !== 1) begin
      failures++;
      $display("FAIL reset_held_pulses got=%0d exp=1", npulse);
    end
    checks++;
    rst_n = 1'b0;
    model_reset();
    #1;
    if ({level_hi, level_lo} !== 2'b00) begin
      failures++;
      $display("FAIL reset_pressed level got=%b exp=00", {level_hi, level_lo});
    end
    checks++;
    btn_hi = 1'b0;
    btn_lo = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0);
  endtask

  task automatic test_long_hold();
    int edges[$];
`ifdef BTN_AUTO_REPEAT_EN
    int exp_edges[$] = '{LAT, LAT + RD, LAT + RD + RP, LAT + RD + 2 * RP};
`else
    int exp_edges[$] = '{LAT};
`endif
    for (int i = 1; i <= 90; i++) begin
      step(1'b1);
      if ({level_hi, pulse_hi, level_lo, pulse_lo} !== {m_level, m_pulse, m_level, m_pulse}) begin
        failures++;
        $display("FAIL long_hold cyc=%0d got=%b exp=%b", i,
                 {level_hi, pulse_hi, level_lo, pulse_lo}, {m_level, m_pulse, m_level, m_pulse});
      end
      checks++;
      if (pulse_hi) edges.push_back(i);
    end
    if (edges.size() !== exp_edges.size()) begin
      failures++;
      $display("FAIL long_hold_count got=%0d exp=%0d", edges.size(), exp_edges.size());
    end else begin
      foreach (edges[k]) begin
        if (edges[k] !== exp_edges[k]) begin
          failures++;
          $display("FAIL long_hold_edge idx=%0d got=%0d exp=%0d", k, edges[k], exp_edges[k]);
        end
      end
    end
    checks++;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0);
      if (pulse_hi !== 1'b0 || pulse_lo !== 1'b0) begin
        failures++;
        $display("FAIL release_no_pulse cyc=%0d got=%b%b exp=00", i, pulse_hi, pulse_lo);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    logic p = 1'b0;
    int left = 0;
    logic prev_pulse = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (left == 0) begin
        p = ~p;
        left = (($urandom % 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 12));
      end
      left--;
      step(p);
      if ({level_hi, pulse_hi, level_lo, pulse_lo} !== {m_level, m_pulse, m_level, m_pulse}) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i,
                 {level_hi, pulse_hi, level_lo, pulse_lo}, {m_level, m_pulse, m_level, m_pulse});
      end
      checks++;
      if (prev_pulse && pulse_hi) begin
        failures++;
        $display("FAIL pulse_twice cyc=%0d got=11 exp=not both", i);
      end
      prev_pulse = pulse_hi;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    btn_hi = 1'b0;
    btn_lo = 1'b1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_tap_glitch();
    test_reset_mid();
    test_long_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
